// File: rtl/regfile_ctrl_pkg.sv
// Shared register-file constants for the NPC core (RV32E).
package regfile_ctrl_pkg;

  localparam int unsigned RF_IDX_W    = 4;
  localparam int unsigned RF_NUM_REGS = 16;
  localparam int unsigned RF_ZERO_IDX = 0;
  localparam int unsigned RF_DATA_W   = 32;

endpackage

// File: rtl/regfile_ctrl_wb_arbiter.sv
// Arbitrates EXU/LSU writebacks onto the single register-file write port,
// LSU first, with a starvation counter that eventually forces an EXU grant.
module regfile_ctrl_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned REGS_DIG   = RF_IDX_W,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exu_wb_valid,
  input  logic [REGS_DIG-1:0]  exu_wb_rd,
  input  logic [RF_DATA_W-1:0] exu_wb_data,
  input  logic                 lsu_wb_valid,
  input  logic [REGS_DIG-1:0]  lsu_wb_rd,
  input  logic [RF_DATA_W-1:0] lsu_wb_data,
  output logic                 exu_wb_ready,
  output logic                 lsu_wb_ready,
  output logic [REGS_DIG-1:0]  rd,
  output logic                 reg_write,
  output logic [RF_DATA_W-1:0] result
);

  localparam int unsigned CNT_W = 2;

  logic [CNT_W-1:0] starve_cnt;
  logic             force_exu;

  assign force_exu    = (starve_cnt == CNT_W'(STARVE_MAX));
  assign lsu_wb_ready = lsu_wb_valid && !force_exu;
  assign exu_wb_ready = exu_wb_valid && (!lsu_wb_valid || force_exu);

  // Count consecutive EXU refusals; any EXU grant restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (exu_wb_valid && exu_wb_ready) begin
      starve_cnt <= '0;
    end else if (exu_wb_valid) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Write-port mux: the granted channel drives the port, otherwise all zero.
  always_comb begin
    rd        = '0;
    result    = '0;
    reg_write = 1'b0;
    if (lsu_wb_ready) begin
      rd        = lsu_wb_rd;
      result    = lsu_wb_data;
      reg_write = 1'b1;
    end else if (exu_wb_ready) begin
      rd        = exu_wb_rd;
      result    = exu_wb_data;
      reg_write = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file controller: busy scoreboard, issue hazard check, writeback
// arbitration onto the single write port, idle and sticky protocol error.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned REGS_DIG   = RF_IDX_W,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic [REGS_DIG-1:0]     issue_rs1,
  input  logic [REGS_DIG-1:0]     issue_rs2,
  input  logic [REGS_DIG-1:0]     issue_rd,
  input  logic                    issue_rd_we,
  output logic                    issue_ready,
  input  logic                    exu_wb_valid,
  input  logic [REGS_DIG-1:0]     exu_wb_rd,
  input  logic [RF_DATA_W-1:0]    exu_wb_data,
  input  logic                    lsu_wb_valid,
  input  logic [REGS_DIG-1:0]     lsu_wb_rd,
  input  logic [RF_DATA_W-1:0]    lsu_wb_data,
  output logic                    exu_wb_ready,
  output logic                    lsu_wb_ready,
  output logic [REGS_DIG-1:0]     rd,
  output logic                    reg_write,
  output logic [RF_DATA_W-1:0]    result,
  output logic [2**REGS_DIG-1:0]  busy,
  output logic                    idle,
  output logic                    err
);

  localparam logic [REGS_DIG-1:0] ZERO_IDX = REGS_DIG'(RF_ZERO_IDX);

  logic [2**REGS_DIG-1:0] busy_d;
  logic                   issue_fire;
  logic                   exu_fire;
  logic                   lsu_fire;
  logic                   err_set;

  regfile_ctrl_wb_arbiter #(
    .REGS_DIG  (REGS_DIG),
    .STARVE_MAX(STARVE_MAX)
  ) u_wb_arbiter (
    .clk         (clk),
    .rst         (rst),
    .exu_wb_valid(exu_wb_valid),
    .exu_wb_rd   (exu_wb_rd),
    .exu_wb_data (exu_wb_data),
    .lsu_wb_valid(lsu_wb_valid),
    .lsu_wb_rd   (lsu_wb_rd),
    .lsu_wb_data (lsu_wb_data),
    .exu_wb_ready(exu_wb_ready),
    .lsu_wb_ready(lsu_wb_ready),
    .rd          (rd),
    .reg_write   (reg_write),
    .result      (result)
  );

  assign exu_fire   = exu_wb_valid && exu_wb_ready;
  assign lsu_fire   = lsu_wb_valid && lsu_wb_ready;
  assign issue_fire = issue_valid && issue_ready;

  // Hazard check against registered busy only; no writeback bypass.
  assign issue_ready = !(busy[issue_rs1] | busy[issue_rs2] | (issue_rd_we & busy[issue_rd]));

  assign idle = (busy == '0) && !exu_wb_valid && !lsu_wb_valid;

  // Next scoreboard: clears from writebacks first so a same-index set wins.
  always_comb begin
    busy_d = busy;
    if (exu_fire) busy_d[exu_wb_rd] = 1'b0;
    if (lsu_fire) busy_d[lsu_wb_rd] = 1'b0;
    if (issue_fire && issue_rd_we && (issue_rd != ZERO_IDX)) busy_d[issue_rd] = 1'b1;
    busy_d[RF_ZERO_IDX] = 1'b0;
  end

  // Protocol violations: write to x0, write to a non-busy tag, dual write same tag.
  always_comb begin
    err_set = 1'b0;
    if (exu_fire && ((exu_wb_rd == ZERO_IDX) || !busy[exu_wb_rd])) err_set = 1'b1;
    if (lsu_fire && ((lsu_wb_rd == ZERO_IDX) || !busy[lsu_wb_rd])) err_set = 1'b1;
    if (exu_fire && lsu_fire && (exu_wb_rd == lsu_wb_rd)) err_set = 1'b1;
  end

  // Scoreboard and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_d;
      if (err_set) err <= 1'b1;
    end
  end

endmodule
